// File: rtl/mips32_mem_pkg.sv
// Shared definitions for the MIPS32 unified-memory arbiter.
//   tag_e      : owner tag carried alongside each memory command.
//   PRIO_*     : bit positions in the request vector. A higher index means
//                a higher fixed priority (DBG > DM > IF).
//   pick_owner : fixed-priority pick with the IF starvation override.
package mips32_mem_pkg;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_DM   = 2'd2,
    TAG_DBG  = 2'd3
  } tag_e;

  localparam int PRIO_IF  = 0;
  localparam int PRIO_DM  = 1;
  localparam int PRIO_DBG = 2;

  // A starving IF beats everything. Otherwise the highest set PRIO_* bit wins.
  function automatic tag_e pick_owner(input logic [2:0] req_vec, input logic force_if);
    tag_e t;
    t = TAG_NONE;
    if (force_if && req_vec[PRIO_IF]) t = TAG_IF;
    else if (req_vec[PRIO_DBG])       t = TAG_DBG;
    else if (req_vec[PRIO_DM])        t = TAG_DM;
    else if (req_vec[PRIO_IF])        t = TAG_IF;
    return t;
  endfunction

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// Requester and memory bus bundle for mips32_mem_arbiter.
//   slave  : the arbiter's view. Requests and mem_rdata come in; grants,
//            read returns, the memory command and stall_cnt go out.
//   master : the environment's view (pipeline stages plus memory macro).
interface mips32_mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [15:0]   stall_cnt;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output stall_cnt
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  stall_cnt
  );
endinterface

// File: rtl/mips32_tag_pipe.sv
// Owner-tag delay line with DEPTH stages (DEPTH = memory read latency).
//   clk1    : clock, rising edge
//   rst_n   : async active-low clear. All stages go to TAG_NONE, so any
//             in-flight read is dropped.
//   tag_in  : tag pushed this cycle (TAG_NONE for writes and idle cycles)
//   tag_out : tag pushed DEPTH cycles ago
module mips32_tag_pipe
  import mips32_mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk1,
  input  logic rst_n,
  input  tag_e tag_in,
  output tag_e tag_out
);

  tag_e pipe_q [DEPTH];
  tag_e pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= TAG_NONE;
    end else begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter shared by IF, DM and DBG.
//   clk1  : clock, rising edge
//   rst_n : async active-low reset
//   bus   : mips32_mem_arbiter_if.slave, which carries:
//           - the three requesters' req/addr/we/wdata inputs and their
//             gnt/rvalid/rdata outputs;
//           - the memory command (mem_en/we/addr/wdata) and mem_rdata;
//           - stall_cnt, a saturating count of cycles in which at least one
//             request was denied.
// Grants are combinational from the requests. The priority is DBG > DM > IF,
// except that an IF starved for STARVE_MAX consecutive cycles wins outright.
// Each read's owner tag travels through a MEM_LAT-deep pipe so the data that
// comes back is flagged to the right requester. MEM_LAT must be 1..4.
module mips32_mem_arbiter
  import mips32_mem_pkg::*;
#(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk1,
  input  logic                 rst_n,
  mips32_mem_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [15:0]   stall_cnt_q, stall_cnt_d;
  logic [2:0]    req_vec;
  logic          starved, denied;
  logic          if_gnt, dm_gnt, dbg_gnt;
  tag_e          gnt_tag, push_tag, tail_tag;

  always_comb begin
    req_vec           = '0;
    req_vec[PRIO_IF]  = bus.if_req;
    req_vec[PRIO_DM]  = bus.dm_req;
    req_vec[PRIO_DBG] = bus.dbg_req;
  end

  assign starved = (starve_cnt_q == SW'(STARVE_MAX));
  // Grants are gated by rst_n so that none can appear while reset is held,
  // even though the requests themselves may still be high.
  assign gnt_tag = rst_n ? pick_owner(req_vec, starved) : TAG_NONE;

  assign if_gnt  = (gnt_tag == TAG_IF);
  assign dm_gnt  = (gnt_tag == TAG_DM);
  assign dbg_gnt = (gnt_tag == TAG_DBG);

  assign bus.if_gnt  = if_gnt;
  assign bus.dm_gnt  = dm_gnt;
  assign bus.dbg_gnt = dbg_gnt;

  // Memory command mux. Only accepted reads push a tag into the pipe.
  always_comb begin
    bus.mem_en    = if_gnt | dm_gnt | dbg_gnt;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {AW{1'b0}};
    bus.mem_wdata = {DW{1'b0}};
    push_tag      = TAG_NONE;
    unique case (gnt_tag)
      TAG_IF: begin
        bus.mem_addr = bus.if_addr;
        push_tag     = TAG_IF;
      end
      TAG_DM: begin
        bus.mem_we    = bus.dm_we;
        bus.mem_addr  = bus.dm_addr;
        bus.mem_wdata = bus.dm_wdata;
        push_tag      = bus.dm_we ? TAG_NONE : TAG_DM;
      end
      TAG_DBG: begin
        bus.mem_we    = bus.dbg_we;
        bus.mem_addr  = bus.dbg_addr;
        bus.mem_wdata = bus.dbg_wdata;
        push_tag      = bus.dbg_we ? TAG_NONE : TAG_DBG;
      end
      default: ;
    endcase
  end

  assign denied = (bus.if_req  & ~if_gnt) |
                  (bus.dm_req  & ~dm_gnt) |
                  (bus.dbg_req & ~dbg_gnt);

  always_comb begin
    starve_cnt_d = '0;
    if (bus.if_req && !if_gnt)
      starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + SW'(1);
    stall_cnt_d = (denied && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  mips32_tag_pipe #(.DEPTH(MEM_LAT)) u_tag_pipe (
    .clk1    (clk1),
    .rst_n   (rst_n),
    .tag_in  (push_tag),
    .tag_out (tail_tag)
  );

  assign bus.if_rvalid  = (tail_tag == TAG_IF);
  assign bus.dm_rvalid  = (tail_tag == TAG_DM);
  assign bus.dbg_rvalid = (tail_tag == TAG_DBG);
  assign bus.if_rdata   = bus.mem_rdata;
  assign bus.dm_rdata   = bus.mem_rdata;
  assign bus.dbg_rdata  = bus.mem_rdata;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Bench for mips32_mem_arbiter. Two instances are used:
//   u_dut1 : MEM_LAT=1. It is driven by directed and random traffic and
//            checked every cycle against a reference model kept in this
//            file: priority rules, a return queue, a memory image and the
//            counters.
//   u_dut2 : MEM_LAT=3. It covers the read latency and a reset that lands
//            while a read is still in flight.
module tb_mips32_mem_arbiter;

  localparam int STARVE = 4;
  localparam int LAT1   = 1;
  localparam int O_NONE = 0, O_IF = 1, O_DM = 2, O_DBG = 3;

  logic clk = 1'b0;
  logic rst1_n, rst2_n;
  always #5 clk = ~clk;

  mips32_mem_arbiter_if #(.AW(10), .DW(32)) b1 ();
  mips32_mem_arbiter_if #(.AW(10), .DW(32)) b2 ();

  mips32_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(LAT1), .STARVE_MAX(STARVE)) u_dut1 (
    .clk1(clk), .rst_n(rst1_n), .bus(b1));
  mips32_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(3), .STARVE_MAX(STARVE)) u_dut2 (
    .clk1(clk), .rst_n(rst2_n), .bus(b2));

  // Memory macros used as the environment: a 1-cycle memory and a 3-cycle memory.
  logic [31:0] mem1 [1024];
  logic [31:0] rd1;
  always @(posedge clk)
    if (b1.mem_en) begin
      if (b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
      else           rd1 <= mem1[b1.mem_addr];
    end
  assign b1.mem_rdata = rd1;

  logic [31:0] mem2 [1024];
  logic [31:0] d2 [3];
  always @(posedge clk) begin
    if (b2.mem_en && b2.mem_we) mem2[b2.mem_addr] <= b2.mem_wdata;
    d2[0] <= mem2[b2.mem_addr];
    d2[1] <= d2[0];
    d2[2] <= d2[1];
  end
  assign b2.mem_rdata = d2[2];

  // Reference model state.
  typedef struct { int tag; logic [31:0] data; int cyc_due; } rd_t;
  rd_t         rq[$];
  logic [31:0] ref_mem [1024];
  int          m_starve, m_stall, cyc;
  logic        g_if, g_dm, g_dbg;
  logic        obs_if_gnt, obs_dm_gnt, obs_dbg_gnt;
  logic        obs_if_rv, obs_dm_rv, obs_dbg_rv;
  logic [31:0] obs_if_rdata, obs_dm_rdata;
  logic [15:0] obs_stall;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic set_if(input logic r, input logic [9:0] a);
    b1.if_req = r; b1.if_addr = a;
  endtask
  task automatic set_dm(input logic r, input logic we, input logic [9:0] a, input logic [31:0] d);
    b1.dm_req = r; b1.dm_we = we; b1.dm_addr = a; b1.dm_wdata = d;
  endtask
  task automatic set_dbg(input logic r, input logic we, input logic [9:0] a, input logic [31:0] d);
    b1.dbg_req = r; b1.dbg_we = we; b1.dbg_addr = a; b1.dbg_wdata = d;
  endtask
  task automatic idle1();
    set_if(0, 0); set_dm(0, 0, 0, 0); set_dbg(0, 0, 0, 0);
  endtask
  task automatic idle2();
    b2.if_req = 0; b2.if_addr = 0;
    b2.dm_req = 0; b2.dm_we = 0; b2.dm_addr = 0; b2.dm_wdata = 0;
    b2.dbg_req = 0; b2.dbg_we = 0; b2.dbg_addr = 0; b2.dbg_wdata = 0;
  endtask

  // One DUT1 cycle. At the falling edge it checks everything against the
  // model and then advances the model. It returns #1 after the next rising edge.
  task automatic step();
    int e, rv;
    logic rd, denied;
    logic [9:0] a;
    logic [31:0] wd;
    @(negedge clk);
    e = O_NONE;
    if (b1.if_req && m_starve == STARVE) e = O_IF;
    else if (b1.dbg_req)                 e = O_DBG;
    else if (b1.dm_req)                  e = O_DM;
    else if (b1.if_req)                  e = O_IF;
    rd = 1'b0; a = '0; wd = '0;
    case (e)
      O_IF:  begin rd = 1'b1;       a = b1.if_addr;  wd = '0;           end
      O_DM:  begin rd = !b1.dm_we;  a = b1.dm_addr;  wd = b1.dm_wdata;  end
      O_DBG: begin rd = !b1.dbg_we; a = b1.dbg_addr; wd = b1.dbg_wdata; end
      default: ;
    endcase
    rv = (rq.size() != 0 && rq[0].cyc_due == cyc) ? rq[0].tag : O_NONE;

    obs_if_gnt = b1.if_gnt; obs_dm_gnt = b1.dm_gnt; obs_dbg_gnt = b1.dbg_gnt;
    obs_if_rv = b1.if_rvalid; obs_dm_rv = b1.dm_rvalid; obs_dbg_rv = b1.dbg_rvalid;
    obs_if_rdata = b1.if_rdata; obs_dm_rdata = b1.dm_rdata; obs_stall = b1.stall_cnt;

    chk("if_gnt",  b1.if_gnt,  e == O_IF);
    chk("dm_gnt",  b1.dm_gnt,  e == O_DM);
    chk("dbg_gnt", b1.dbg_gnt, e == O_DBG);
    chk("mem_en",  b1.mem_en,  e != O_NONE);
    if (e != O_NONE) begin
      chk("mem_we",    b1.mem_we,    !rd);
      chk("mem_addr",  b1.mem_addr,  a);
      chk("mem_wdata", b1.mem_wdata, wd);
    end
    chk("if_rvalid",  b1.if_rvalid,  rv == O_IF);
    chk("dm_rvalid",  b1.dm_rvalid,  rv == O_DM);
    chk("dbg_rvalid", b1.dbg_rvalid, rv == O_DBG);
    if (rv == O_IF)  chk("if_rdata",  b1.if_rdata,  rq[0].data);
    if (rv == O_DM)  chk("dm_rdata",  b1.dm_rdata,  rq[0].data);
    if (rv == O_DBG) chk("dbg_rdata", b1.dbg_rdata, rq[0].data);
    if (rv != O_NONE) void'(rq.pop_front());
    chk("stall_cnt", b1.stall_cnt, m_stall);

    if (e != O_NONE) begin
      if (rd) rq.push_back('{e, ref_mem[a], cyc + LAT1});
      else    ref_mem[a] = wd;
    end
    denied = (b1.if_req && e != O_IF) || (b1.dm_req && e != O_DM) || (b1.dbg_req && e != O_DBG);
    if (denied && m_stall < 65535) m_stall++;
    if (b1.if_req && e != O_IF) m_starve = (m_starve < STARVE) ? m_starve + 1 : STARVE;
    else                        m_starve = 0;
    g_if = (e == O_IF); g_dm = (e == O_DM); g_dbg = (e == O_DBG);
    @(posedge clk); #1;
    cyc++;
  endtask

  // Reset asserted mid-cycle while every requester is asking.
  task automatic reset1();
    set_if(1, 1); set_dm(1, 0, 2, 0); set_dbg(1, 0, 3, 0);
    rst1_n = 1'b0;
    @(negedge clk);
    chk("rst_if_gnt",  b1.if_gnt,  0);
    chk("rst_dm_gnt",  b1.dm_gnt,  0);
    chk("rst_dbg_gnt", b1.dbg_gnt, 0);
    chk("rst_mem_en",  b1.mem_en,  0);
    chk("rst_rvalid",  {b1.if_rvalid, b1.dm_rvalid, b1.dbg_rvalid}, 0);
    chk("rst_stall",   b1.stall_cnt, 0);
    @(posedge clk); #1;
    idle1();
    rst1_n = 1'b1;
    rq.delete(); m_starve = 0; m_stall = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst1_n = 1'b0; rst2_n = 1'b0;
    idle1(); idle2();
    cyc = 0; m_starve = 0; m_stall = 0;
    g_if = 0; g_dm = 0; g_dbg = 0;
    repeat (2) @(posedge clk);
    #1;
    rst2_n = 1'b1;

    // ---------------- DUT2: MEM_LAT = 3 ----------------
    b2.dbg_req = 1; b2.dbg_we = 1; b2.dbg_addr = 9; b2.dbg_wdata = 32'hC0DE0009;
    @(negedge clk); chk("l3_pre9_gnt", b2.dbg_gnt, 1);
    @(posedge clk); #1;
    b2.dbg_addr = 4; b2.dbg_wdata = 32'hC0DE0004;
    @(negedge clk); chk("l3_pre4_gnt", b2.dbg_gnt, 1);
    @(posedge clk); #1;
    idle2();
    b2.dm_req = 1; b2.dm_addr = 9;
    @(negedge clk); chk("l3_rd_gnt", b2.dm_gnt, 1);
    @(posedge clk); #1;
    idle2();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("l3_rvalid", b2.dm_rvalid, k == 3);
      if (k == 3) chk("l3_rdata", b2.dm_rdata, 32'hC0DE0009);
      @(posedge clk); #1;
    end
    // Accepted read and a denied IF, then reset lands one cycle later.
    b2.dm_req = 1; b2.dm_addr = 4; b2.if_req = 1; b2.if_addr = 4;
    @(negedge clk);
    chk("l3_mid_dm_gnt", b2.dm_gnt, 1);
    chk("l3_mid_if_gnt", b2.if_gnt, 0);
    @(posedge clk); #1;
    chk("l3_stall_pre", b2.stall_cnt, 1);
    b2.dm_req = 0; b2.dbg_req = 1; b2.dbg_addr = 4;
    rst2_n = 1'b0;
    @(negedge clk);
    chk("l3_rst_gnt", {b2.if_gnt, b2.dm_gnt, b2.dbg_gnt}, 0);
    chk("l3_rst_mem_en", b2.mem_en, 0);
    chk("l3_rst_rvalid", {b2.if_rvalid, b2.dm_rvalid, b2.dbg_rvalid}, 0);
    @(posedge clk); #1;
    rst2_n = 1'b1;
    idle2();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("l3_post_rvalid", {b2.if_rvalid, b2.dm_rvalid, b2.dbg_rvalid}, 0);
      chk("l3_post_stall", b2.stall_cnt, 0);
      @(posedge clk); #1;
    end

    // ---------------- DUT1: MEM_LAT = 1 ----------------
    reset1();
    for (int i = 0; i < 16; i++) begin
      set_dbg(1, 1, 10'(i), $urandom);
      step();
    end
    idle1();

    // Solo IF read
    set_dbg(1, 1, 5, 32'h10400014); step();
    set_dbg(0, 0, 0, 0);
    set_if(1, 5); step();
    chk("solo_if_gnt", obs_if_gnt, 1);
    set_if(0, 0); step();
    chk("solo_if_rv", obs_if_rv, 1);
    chk("solo_if_rdata", obs_if_rdata, 32'h10400014);
    chk("solo_other_rv", {obs_dm_rv, obs_dbg_rv}, 0);

    // Three-way contention
    set_if(1, 1); set_dm(1, 0, 2, 0); set_dbg(1, 0, 3, 0);
    step(); chk("c3_dbg_first", obs_dbg_gnt, 1);
    set_dbg(0, 0, 0, 0);
    step(); chk("c3_dm_second", obs_dm_gnt, 1); chk("c3_dbg_ret", obs_dbg_rv, 1);
    set_dm(0, 0, 0, 0);
    step(); chk("c3_if_third", obs_if_gnt, 1); chk("c3_dm_ret", obs_dm_rv, 1);
    set_if(0, 0);
    step(); chk("c3_if_ret", obs_if_rv, 1);

    // Write then read
    set_dm(1, 1, 3, 32'h0000002A); step();
    chk("wr_gnt", obs_dm_gnt, 1);
    set_dm(1, 0, 3, 0); step();
    chk("wr_no_rv", {obs_if_rv, obs_dm_rv, obs_dbg_rv}, 0);
    set_dm(0, 0, 0, 0); step();
    chk("rd_rv", obs_dm_rv, 1);
    chk("rd_data", obs_dm_rdata, 32'h0000002A);

    // Starvation
    reset1();
    set_dm(1, 0, 7, 0); set_if(1, 8);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("starve_if_gnt", obs_if_gnt, k == 4);
      chk("starve_dm_gnt", obs_dm_gnt, k != 4);
      if (k == 4) set_if(0, 0);
      if (k == 5) chk("starve_stall", obs_stall, 5);
    end
    idle1();

    // Random traffic; a requester holds its request until it is granted.
    for (int n = 0; n < 600; n++) begin
      if (!b1.if_req || g_if) set_if(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)));
      if (!b1.dm_req || g_dm)
        set_dm(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom);
      if (!b1.dbg_req || g_dbg)
        set_dbg(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom);
      step();
    end
    idle1();
    repeat (3) step();

    // Saturation: someone is denied every cycle.
    reset1();
    set_if(1, 1); set_dm(1, 0, 2, 0); set_dbg(1, 0, 3, 0);
    repeat (65600) step();
    chk("stall_sat", obs_stall, 16'hFFFF);
    idle1();
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mips32_mem_arbiter.md
# mips32_mem_arbiter

Single-port memory arbiter for the MIPS32 core: shares one unified instruction/data memory between three requesters. The requesters are instruction fetch (IF), the data-memory stage (DM, loads/stores) and a debug/loader port (DBG, program preload and register-dump support). The block sits between the pipeline stages and the memory macro. It grants at most one access per cycle, tracks in-flight reads so each read returns to its owner, and prevents IF starvation.

## Interface
- AW, default 10: word-address width.
- DW, default 32: data width.
- MEM_LAT, default 1: cycles from accept to read data; legal range is 1..4.
- STARVE_MAX, default 4: consecutive denied IF cycles before IF is forced to top priority.
- clk1  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  IF read request; if_addr  in  AW; if_gnt  out  1; if_rvalid  out  1; if_rdata  out  DW.
- dm_req  in  1; dm_we  in  1; dm_addr  in  AW; dm_wdata  in  DW; dm_gnt  out  1; dm_rvalid  out  1; dm_rdata  out  DW.
- dbg_req  in  1; dbg_we  in  1; dbg_addr  in  AW; dbg_wdata  in  DW; dbg_gnt  out  1; dbg_rvalid  out  1; dbg_rdata  out  DW.
- mem_en  out  1; mem_we  out  1; mem_addr  out  AW; mem_wdata  out  DW: memory command, sampled by the memory at the rising edge.
- mem_rdata  in  DW: valid MEM_LAT cycles after a read command.
- stall_cnt  out  16: saturating count of cycles with at least one denied request.

## Operation
- Handshake: a transfer occurs in a cycle where req && gnt. The requester holds req, addr, we and wdata stable until granted. gnt is combinational from the req inputs and the starvation state.
- Priority: DBG > DM > IF. Exception: when starve_cnt == STARVE_MAX, IF wins over both DM and DBG.
- At most one gnt is high per cycle. With no req high, all gnt are 0 and mem_en is 0.
- Memory command: mem_en = OR of the gnts. mem_we, mem_addr and mem_wdata are muxed from the granted requester. For IF, mem_we = 0 and mem_wdata = 0.
- Tag pipeline: each accepted read pushes its owner tag (IF/DM/DBG) into a MEM_LAT-deep shift register. Writes and idle cycles push NONE. The tag at the pipeline tail selects which rvalid pulses.
- All three rdata outputs equal mem_rdata. Only the rvalid of the owner is asserted.
- Starvation counter (width $clog2(STARVE_MAX+1)):
  - Increments, saturating at STARVE_MAX, on each cycle with if_req && !if_gnt.
  - Clears on if_gnt or when if_req is low.
- stall_cnt increments on any cycle where some req is high without its gnt. It saturates at 16'hFFFF.

## Timing
- Read accepted in cycle t: owner rvalid is high for exactly one cycle, at cycle t+MEM_LAT. rdata is valid in that cycle.
- Back-to-back reads from different owners each return in order, one per cycle.
- Write accepted in cycle t: memory is updated at the end of cycle t. No rvalid is produced.
- A write accepted in cycle t followed by a read of the same address in cycle t+1 returns the new data.
- Reset (rst_n low, at any time):
  - All gnt, rvalid and mem_en are forced to 0.
  - The tag pipeline is cleared to NONE; in-flight reads are discarded and never produce rvalid after reset.
  - starve_cnt and stall_cnt are cleared to 0.
- First grant is possible in the first cycle after rst_n deasserts.
- Simultaneous IF starvation and DBG request: IF is granted, DBG waits. starve_cnt clears, so DBG wins the following cycle.

## Structure
- Shared package mips32_mem_pkg holds:
  - owner tag enum, 2-bit: TAG_NONE=0, TAG_IF=1, TAG_DM=2, TAG_DBG=3;
  - the DBG > DM > IF priority encoding constants.
- One sub-module, mips32_tag_pipe: a parameterised MEM_LAT-deep tag shift register with async active-low clear.
- Grant logic, starvation counter and stall counter live in the top module.

## Test plan
- **Solo IF read:** preload addr 5 = 32'h10400014 via DBG write; IF requests addr 5 -> if_gnt in the same cycle, if_rvalid one cycle later (MEM_LAT=1) with if_rdata = 32'h10400014, dm_rvalid and dbg_rvalid stay 0.
- **Three-way contention:** DBG, DM and IF all request in one cycle -> grant order DBG, DM, IF over three consecutive cycles; rvalids return to the matching owners in the same order.
- **Starvation:** DM requests continuously with STARVE_MAX=4 while IF requests -> IF denied 4 cycles then granted on the 5th; DM regains the grant the next cycle; stall_cnt = 5 (4 IF-denied cycles plus the cycle DM is denied).
- **Write then read:** DM writes 32'h0000002A to addr 3 and reads addr 3 the next cycle -> dm_rdata = 32'h0000002A; no rvalid for the write.
- **Reset mid-read (MEM_LAT=3):** read accepted, rst_n pulsed low one cycle later -> no rvalid ever appears for that read; all gnt=0 during reset; stall_cnt=0 afterward.
- **Saturation:** IF denied for 70000 cycles -> stall_cnt holds 16'hFFFF and does not wrap to 0.
